// File: rtl/dmem_access_ctrl_if.sv
// SRAM-like data bus between the MEM-stage sequencer and the data SRAM.
// Handshake: sram_req/sram_addr_ok for the address phase, sram_data_ok for completion.
// The master holds every request field stable while sram_req is high and addr_ok is low.
interface dmem_access_ctrl_if;
    logic        sram_req;
    logic        sram_wr;
    logic [1:0]  sram_size;
    logic [31:0] sram_addr;
    logic [3:0]  sram_wstrb;
    logic [31:0] sram_wdata;
    logic        sram_addr_ok;
    logic        sram_data_ok;
    logic [31:0] sram_rdata;

    modport master (
        output sram_req, sram_wr, sram_size, sram_addr, sram_wstrb, sram_wdata,
        input  sram_addr_ok, sram_data_ok, sram_rdata
    );

    modport slave (
        input  sram_req, sram_wr, sram_size, sram_addr, sram_wstrb, sram_wdata,
        output sram_addr_ok, sram_data_ok, sram_rdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Data SRAM access sequencer: one load/store per EX request, strobes, lane replication, load extend.
// Latency: 3 stall cycles against a zero-wait slave (2 with combined addr_ok+data_ok), 1 for misalign.
// Backpressure: stallreq holds the pipeline until DONE; optional watchdog via DMEM_CTRL_TIMEOUT_EN.
module dmem_access_ctrl
`ifdef DMEM_CTRL_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 256
)
`endif
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_wr,
    input  logic [1:0]            req_size,
    input  logic                  req_sext,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  stallreq,
    output logic [31:0]           rdata,
    output logic                  rdata_valid,
    output logic                  err,
    dmem_access_ctrl_if.master    sram
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t      state_q;
    logic        wr_q;
    logic [1:0]  size_q;      // already normalised: 3 is stored as 2
    logic        sext_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        misalign;
    logic [1:0]  size_norm;
    logic [31:0] load_d;      // extended load value for the current response
    logic [31:0] result_d;    // value written to rdata on completion (stores give 0)

`ifdef DMEM_CTRL_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             timeout;
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    // Alignment check and size normalisation on the incoming EX request.
    always_comb begin
        size_norm = (req_size == 2'd3) ? 2'd2 : req_size;
        misalign  = 1'b0;
        if (size_norm == 2'd1)
            misalign = req_addr[0];
        else if (size_norm == 2'd2)
            misalign = (req_addr[1:0] != 2'b00);
    end

    // Pick the addressed lane of the read data and sign/zero extend it.
    always_comb begin
        load_d = sram.sram_rdata;
        case (size_q)
            2'd0: begin
                logic [7:0] b;
                case (addr_q[1:0])
                    2'd0:    b = sram.sram_rdata[7:0];
                    2'd1:    b = sram.sram_rdata[15:8];
                    2'd2:    b = sram.sram_rdata[23:16];
                    default: b = sram.sram_rdata[31:24];
                endcase
                load_d = {{24{sext_q & b[7]}}, b};
            end
            2'd1: begin
                logic [15:0] h;
                h = addr_q[1] ? sram.sram_rdata[31:16] : sram.sram_rdata[15:0];
                load_d = {{16{sext_q & h[15]}}, h};
            end
            default: load_d = sram.sram_rdata;
        endcase
        result_d = wr_q ? 32'd0 : load_d;
    end

    // Strobes and lane-replicated write data from the latched request.
    always_comb begin
        sram.sram_wstrb = 4'b0000;
        sram.sram_wdata = wdata_q;
        case (size_q)
            2'd0: begin
                sram.sram_wstrb = 4'b0001 << addr_q[1:0];
                sram.sram_wdata = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                sram.sram_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
                sram.sram_wdata = {2{wdata_q[15:0]}};
            end
            default: sram.sram_wstrb = 4'b1111;
        endcase
        if (!wr_q)
            sram.sram_wstrb = 4'b0000;
    end

    // Bus outputs decode the registered state; reset drops them in the same cycle.
    assign sram.sram_req  = (state_q == ADDR) && !rst;
    assign sram.sram_wr   = wr_q;
    assign sram.sram_size = size_q;
    assign sram.sram_addr = addr_q;

    assign stallreq    = !rst && (((state_q == IDLE) && req_valid) ||
                                  (state_q == ADDR) || (state_q == DATA));
    assign rdata_valid = (state_q == DONE) && !rst;
    assign err         = err_q && rdata_valid;
    assign rdata       = rdata_q;

    // Access sequencer: latch in IDLE, address phase, data phase, one-cycle completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            sext_q  <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
`ifdef DMEM_CTRL_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    err_q <= 1'b0;
                    if (req_valid) begin
                        if (misalign) begin
                            state_q <= DONE;
                            err_q   <= 1'b1;
                            rdata_q <= 32'd0;
                        end else begin
                            state_q <= ADDR;
                            wr_q    <= req_wr;
                            size_q  <= size_norm;
                            sext_q  <= req_sext;
                            addr_q  <= req_addr;
                            wdata_q <= req_wdata;
`ifdef DMEM_CTRL_TIMEOUT_EN
                            cnt_q   <= '0;
`endif
                        end
                    end
                end
                ADDR: begin
                    if (sram.sram_addr_ok && sram.sram_data_ok) begin
                        state_q <= DONE;
                        rdata_q <= result_d;
                    end else if (sram.sram_addr_ok) begin
                        state_q <= DATA;
`ifdef DMEM_CTRL_TIMEOUT_EN
                        cnt_q   <= '0;
                    end else if (timeout) begin
                        state_q <= DONE;
                        err_q   <= 1'b1;
                        rdata_q <= 32'd0;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
`endif
                    end
                end
                DATA: begin
                    if (sram.sram_data_ok) begin
                        state_q <= DONE;
                        rdata_q <= result_d;
`ifdef DMEM_CTRL_TIMEOUT_EN
                    end else if (timeout) begin
                        state_q <= DONE;
                        err_q   <= 1'b1;
                        rdata_q <= 32'd0;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
`endif
                    end
                end
                default: begin
                    // DONE: never re-issue a request still held by EX
                    state_q <= IDLE;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a hand-driven SRAM slave.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_wr, req_sext;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stallreq, rdata_valid, err;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;

    dmem_access_ctrl_if bus();

    dmem_access_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_wr      (req_wr),
        .req_size    (req_size),
        .req_sext    (req_sext),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .stallreq    (stallreq),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .err         (err),
        .sram        (bus.master)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wr, input logic [1:0] size, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_wr    = wr;
        req_size  = size;
        req_sext  = sext;
        req_addr  = addr;
        req_wdata = wdata;
        #1;
    endtask

    // Zero-wait load: leaves the DUT in DONE on return.
    task automatic zero_wait_load(input logic [1:0] size, input logic sext,
                                  input logic [31:0] addr, input logic [31:0] srd);
        issue(1'b0, size, sext, addr, 32'd0);
        tick;
        req_valid = 1'b0;
        bus.sram_addr_ok = 1'b1;
        tick;
        bus.sram_addr_ok = 1'b0;
        bus.sram_data_ok = 1'b1;
        bus.sram_rdata   = srd;
        tick;
        bus.sram_data_ok = 1'b0;
        bus.sram_rdata   = 32'h5555_5555;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 1'b0; req_wr = 1'b0; req_size = 2'd0; req_sext = 1'b0;
        req_addr = 32'd0; req_wdata = 32'd0;
        bus.sram_addr_ok = 1'b0; bus.sram_data_ok = 1'b0; bus.sram_rdata = 32'd0;
        tick; tick;
        checks++; if (bus.sram_req !== 1'b0) begin errors++; $display("FAIL reset_sram_req got %b want 0", bus.sram_req); end
        checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL reset_rdata_valid got %b want 0", rdata_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (stallreq !== 1'b0) begin errors++; $display("FAIL reset_stallreq got %b want 0", stallreq); end
        checks++; if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_word_load;
        int stalls;
        stalls = 0;
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
        if (stallreq === 1'b1) stalls++;                      // C0
        tick;                                                 // C1 ADDR
        req_valid = 1'b0;
        #1;
        checks++; if (bus.sram_req !== 1'b1 || bus.sram_addr !== 32'h100 || bus.sram_size !== 2'd2 || bus.sram_wr !== 1'b0)
            begin errors++; $display("FAIL lw_addr_phase got req=%b addr=%h size=%0d wr=%b want 1 100 2 0", bus.sram_req, bus.sram_addr, bus.sram_size, bus.sram_wr); end
        checks++; if (bus.sram_wstrb !== 4'b0000) begin errors++; $display("FAIL lw_wstrb got %b want 0000", bus.sram_wstrb); end
        if (stallreq === 1'b1) stalls++;
        bus.sram_addr_ok = 1'b1;
        tick;                                                 // C2 DATA
        bus.sram_addr_ok = 1'b0;
        checks++; if (bus.sram_req !== 1'b0) begin errors++; $display("FAIL lw_data_phase_req got %b want 0", bus.sram_req); end
        if (stallreq === 1'b1) stalls++;
        bus.sram_data_ok = 1'b1; bus.sram_rdata = 32'hDEAD_BEEF;
        tick;                                                 // C3 DONE
        bus.sram_data_ok = 1'b0; bus.sram_rdata = 32'd0;
        #1;
        if (stallreq === 1'b1) stalls++;
        checks++; if (stalls !== 3) begin errors++; $display("FAIL lw_stall_cycles got %0d want 3", stalls); end
        checks++; if (rdata_valid !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL lw_done got valid=%b err=%b want 1 0", rdata_valid, err); end
        checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_rdata got %h want deadbeef", rdata); end
        tick;                                                 // IDLE
        checks++; if (rdata_valid !== 1'b0 || rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_hold got valid=%b rdata=%h want 0 deadbeef", rdata_valid, rdata); end
    endtask

    task automatic test_load_extract;
        logic [1:0]  sz   [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0};
        logic        sx   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] ad   [5] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100};
        logic [31:0] srd  [5] = '{32'h8012_3456, 32'h8012_3456, 32'hBEEF_1234, 32'hBEEF_1234, 32'h0000_00F0};
        logic [31:0] exp  [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_BEEF, 32'hFFFF_BEEF, 32'h0000_00F0};
        for (int i = 0; i < 5; i++) begin
            zero_wait_load(sz[i], sx[i], ad[i], srd[i]);
            checks++; if (rdata !== exp[i] || rdata_valid !== 1'b1 || err !== 1'b0)
                begin errors++; $display("FAIL load_ext_%0d got rdata=%h valid=%b err=%b want %h 1 0", i, rdata, rdata_valid, err, exp[i]); end
            tick;
        end
    endtask

    task automatic test_store;
        // sb with combined addr_ok+data_ok: DONE one cycle after the address phase
        issue(1'b1, 2'd0, 1'b0, 32'h201, 32'h0000_00A5);
        tick;
        req_valid = 1'b0;
        #1;
        checks++; if (bus.sram_wstrb !== 4'b0010 || bus.sram_wdata !== 32'hA5A5_A5A5 || bus.sram_wr !== 1'b1 || bus.sram_size !== 2'd0)
            begin errors++; $display("FAIL sb_bus got strb=%b wdata=%h wr=%b size=%0d want 0010 a5a5a5a5 1 0", bus.sram_wstrb, bus.sram_wdata, bus.sram_wr, bus.sram_size); end
        bus.sram_addr_ok = 1'b1; bus.sram_data_ok = 1'b1;
        tick;
        bus.sram_addr_ok = 1'b0; bus.sram_data_ok = 1'b0;
        #1;
        checks++; if (rdata_valid !== 1'b1 || rdata !== 32'd0 || stallreq !== 1'b0)
            begin errors++; $display("FAIL sb_done got valid=%b rdata=%h stall=%b want 1 0 0", rdata_valid, rdata, stallreq); end
        tick;
        // sh upper half, size 3 treated as word for a following sw
        issue(1'b1, 2'd1, 1'b0, 32'h202, 32'h0000_1234);
        tick;
        req_valid = 1'b0;
        #1;
        checks++; if (bus.sram_wstrb !== 4'b1100 || bus.sram_wdata !== 32'h1234_1234)
            begin errors++; $display("FAIL sh_bus got strb=%b wdata=%h want 1100 12341234", bus.sram_wstrb, bus.sram_wdata); end
        bus.sram_addr_ok = 1'b1;
        tick;
        bus.sram_addr_ok = 1'b0; bus.sram_data_ok = 1'b1;
        tick;
        bus.sram_data_ok = 1'b0;
        tick;
        issue(1'b1, 2'd3, 1'b0, 32'h204, 32'h89AB_CDEF);
        tick;
        req_valid = 1'b0;
        #1;
        checks++; if (bus.sram_wstrb !== 4'b1111 || bus.sram_wdata !== 32'h89AB_CDEF || bus.sram_size !== 2'd2)
            begin errors++; $display("FAIL sw_size3 got strb=%b wdata=%h size=%0d want 1111 89abcdef 2", bus.sram_wstrb, bus.sram_wdata, bus.sram_size); end
        bus.sram_addr_ok = 1'b1; bus.sram_data_ok = 1'b1;
        tick;
        bus.sram_addr_ok = 1'b0; bus.sram_data_ok = 1'b0;
        tick;
    endtask

    task automatic test_misalign;
        zero_wait_load(2'd0, 1'b0, 32'h103, 32'h8000_0000);   // rdata = 0x80 before the error
        tick;
        issue(1'b1, 2'd2, 1'b0, 32'h102, 32'h1111_1111);
        checks++; if (stallreq !== 1'b1) begin errors++; $display("FAIL mis_c0_stall got %b want 1", stallreq); end
        tick;                                                  // C1 DONE, req_valid still high
        checks++; if (err !== 1'b1 || rdata_valid !== 1'b1 || bus.sram_req !== 1'b0 || rdata !== 32'd0 || stallreq !== 1'b0)
            begin errors++; $display("FAIL mis_done got err=%b valid=%b req=%b rdata=%h stall=%b want 1 1 0 0 0", err, rdata_valid, bus.sram_req, rdata, stallreq); end
        req_valid = 1'b0;
        tick;
        checks++; if (err !== 1'b0 || rdata_valid !== 1'b0 || bus.sram_req !== 1'b0)
            begin errors++; $display("FAIL mis_no_reissue got err=%b valid=%b req=%b want 0 0 0", err, rdata_valid, bus.sram_req); end
        issue(1'b0, 2'd1, 1'b1, 32'h101, 32'd0);
        tick;
        req_valid = 1'b0;
        #1;
        checks++; if (err !== 1'b1 || bus.sram_req !== 1'b0) begin errors++; $display("FAIL mis_half got err=%b req=%b want 1 0", err, bus.sram_req); end
        tick;
    endtask

    task automatic test_wait_states;
        int req_cycles;
        int stall_low;
        req_cycles = 0; stall_low = 0;
        issue(1'b0, 2'd2, 1'b0, 32'h300, 32'd0);
        tick;
        req_valid = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (bus.sram_req === 1'b1 && bus.sram_addr === 32'h300) req_cycles++;
            if (stallreq !== 1'b1) stall_low++;
            bus.sram_data_ok = (i == 2);                        // stray data_ok in ADDR
            bus.sram_rdata   = 32'hBAD0_BAD0;
            tick;
        end
        bus.sram_data_ok = 1'b0;
        if (bus.sram_req === 1'b1 && bus.sram_addr === 32'h300) req_cycles++;
        if (stallreq !== 1'b1) stall_low++;
        bus.sram_addr_ok = 1'b1;
        tick;
        bus.sram_addr_ok = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (bus.sram_req !== 1'b0) req_cycles++;
            if (stallreq !== 1'b1) stall_low++;
            tick;
        end
        if (stallreq !== 1'b1) stall_low++;
        bus.sram_data_ok = 1'b1; bus.sram_rdata = 32'h1234_5678;
        tick;
        bus.sram_data_ok = 1'b0;
        checks++; if (req_cycles !== 6) begin errors++; $display("FAIL wait_req_cycles got %0d want 6", req_cycles); end
        checks++; if (stall_low !== 0) begin errors++; $display("FAIL wait_stall_low got %0d want 0", stall_low); end
        checks++; if (rdata_valid !== 1'b1 || rdata !== 32'h1234_5678)
            begin errors++; $display("FAIL wait_result got valid=%b rdata=%h want 1 12345678", rdata_valid, rdata); end
        tick;
    endtask

    task automatic test_reset_mid;
        // reset while in ADDR: request drops in the same cycle
        issue(1'b0, 2'd2, 1'b0, 32'h400, 32'd0);
        tick;
        req_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (bus.sram_req !== 1'b0) begin errors++; $display("FAIL rst_addr_req got %b want 0", bus.sram_req); end
        tick;
        rst = 1'b0;
        // reset while in DATA, then a late data_ok must be dropped
        issue(1'b0, 2'd2, 1'b0, 32'h404, 32'd0);
        tick;
        req_valid = 1'b0;
        bus.sram_addr_ok = 1'b1;
        tick;
        bus.sram_addr_ok = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (bus.sram_req !== 1'b0 || stallreq !== 1'b0) begin errors++; $display("FAIL rst_data_outs got req=%b stall=%b want 0 0", bus.sram_req, stallreq); end
        tick;
        rst = 1'b0;
        bus.sram_data_ok = 1'b1; bus.sram_rdata = 32'hCAFE_F00D;
        tick;
        bus.sram_data_ok = 1'b0;
        tick;
        checks++; if (rdata_valid !== 1'b0 || err !== 1'b0 || rdata !== 32'd0 || stallreq !== 1'b0)
            begin errors++; $display("FAIL rst_stray_data got valid=%b err=%b rdata=%h stall=%b want 0 0 0 0", rdata_valid, err, rdata, stallreq); end
        zero_wait_load(2'd1, 1'b0, 32'h406, 32'hA5A5_7777);
        checks++; if (rdata !== 32'h0000_A5A5 || rdata_valid !== 1'b1) begin errors++; $display("FAIL rst_recover got rdata=%h valid=%b want 0000a5a5 1", rdata, rdata_valid); end
        tick;
    endtask

`ifdef DMEM_CTRL_TIMEOUT_EN
    task automatic test_timeout;
        int req_cycles;
        req_cycles = 0;
        issue(1'b0, 2'd2, 1'b0, 32'h500, 32'd0);
        tick;
        req_valid = 1'b0;
        for (int i = 0; i < 400 && rdata_valid !== 1'b1; i++) begin
            if (bus.sram_req === 1'b1) req_cycles++;
            tick;
        end
        checks++; if (rdata_valid !== 1'b1 || err !== 1'b1 || rdata !== 32'd0)
            begin errors++; $display("FAIL timeout_done got valid=%b err=%b rdata=%h want 1 1 0", rdata_valid, err, rdata); end
        checks++; if (req_cycles !== 256) begin errors++; $display("FAIL timeout_cycles got %0d want 256", req_cycles); end
        bus.sram_data_ok = 1'b1;
        tick;
        bus.sram_data_ok = 1'b0;
        checks++; if (rdata_valid !== 1'b0 || stallreq !== 1'b0 || bus.sram_req !== 1'b0)
            begin errors++; $display("FAIL timeout_idle got valid=%b stall=%b req=%b want 0 0 0", rdata_valid, stallreq, bus.sram_req); end
    endtask
`endif

    initial begin
        test_reset;
        test_word_load;
        test_load_extract;
        test_store;
        test_misalign;
        test_wait_states;
        test_reset_mid;
`ifdef DMEM_CTRL_TIMEOUT_EN
        test_timeout;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
